// File: rtl/apb_request_arbiter.sv
// Round-robin arbiter that shares one APB manager request port among NUM_REQ
// requesters, launching one transfer at a time and returning a one-cycle ack.
module apb_request_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  input  logic [32*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     ack,
  output logic [31:0]            rdata,
  output logic                   busy,
  output logic [1:0]             grant_id,
  output logic                   m_transfer,
  output logic                   m_write,
  output logic [31:0]            m_addr,
  output logic [31:0]            m_wdata,
  input  logic [31:0]            m_rdata,
  input  logic                   m_ready,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_XFER   = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               state_q;
  logic [1:0]           rr_ptr_q;
  logic [1:0]           grant_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic [NUM_REQ-1:0]   ack_onehot;
  logic [31:0]          rdata_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic                 busy_q;
  logic                 xfer_q;
  logic                 write_q;

  // Inputs padded to the 4-requester maximum so a 2-bit index always fits.
  logic [3:0]           req_pad;
  logic [3:0]           write_pad;
  logic [127:0]         addr_pad;
  logic [127:0]         wdata_pad;
  logic                 grant_valid_d;
  logic [1:0]           grant_d;
  logic [1:0]           cand;

  assign req_pad   = 4'(req);
  assign write_pad = 4'(req_write);
  assign addr_pad  = 128'(req_addr);
  assign wdata_pad = 128'(req_wdata);

  // Search begins one past the last winner and takes the first set bit.
  always_comb begin
    grant_valid_d = 1'b0;
    grant_d       = '0;
    cand          = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_valid_d && req_pad[cand]) begin
        grant_valid_d = 1'b1;
        grant_d       = cand;
      end
    end
  end

  always_comb begin
    ack_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack_onehot[i] = (grant_q == 2'(i));
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 2'(NUM_REQ - 1);
      grant_q  <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      xfer_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      ack_q  <= '0;
      xfer_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_valid_d) begin
            state_q  <= S_XFER;
            xfer_q   <= 1'b1;
            busy_q   <= 1'b1;
            grant_q  <= grant_d;
            rr_ptr_q <= grant_d;
            write_q  <= write_pad[grant_d];
            addr_q   <= addr_pad[{grant_d, 5'd0} +: 32];
            wdata_q  <= wdata_pad[{grant_d, 5'd0} +: 32];
          end
        end
        S_XFER:  state_q <= S_SETUP;
        // The manager is still in its setup phase, so m_ready is not looked at.
        S_SETUP: state_q <= S_ACCESS;
        S_ACCESS: begin
          if (m_ready) begin
            state_q <= S_DONE;
            ack_q   <= ack_onehot;
            rdata_q <= m_rdata;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign m_transfer = xfer_q;
  assign m_write    = write_q;
  assign m_addr     = addr_q;
  assign m_wdata    = wdata_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/apb_request_arbiter.md
# apb_request_arbiter

Round-robin arbiter and sequencer that shares the APB manager's internal request interface (transfer/write/addr/wdata in, rdata/ready out) among NUM_REQ requesters, e.g. the CPU data port and a DMA engine. It accepts a held request per requester and launches exactly one manager transfer at a time. It tracks the manager's IDLE→SETUP→ACCESS sequence and returns a one-cycle acknowledge with read data to the granted requester. It sits between the requesters and the APB manager in the bus subsystem.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- PCLK  in  1  clock, all logic rising-edge
- PRESET  in  1  reset, asynchronous and active-high
- req  in  NUM_REQ  per-requester request, held high until its ack
- req_write  in  NUM_REQ  per-requester 1=write, 0=read
- req_addr  in  32*NUM_REQ  per-requester address, slice i = [32*i+31:32*i]
- req_wdata  in  32*NUM_REQ  per-requester write data, same slicing
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot or zero
- rdata  out  32  read data, valid only in the ack cycle
- busy  out  1  high whenever the state is not IDLE
- grant_id  out  2  index of the current or last granted requester
- m_transfer  out  1  to manager transfer
- m_write  out  1  to manager write
- m_addr  out  32  to manager addr
- m_wdata  out  32  to manager wdata
- m_rdata  in  32  from manager rdata
- m_ready  in  1  from manager ready

## Operation
- FSM states: IDLE, XFER, SETUP, ACCESS, DONE. All outputs are registered or decoded from registered state only. No output has a combinational path from an input.
- IDLE: if any req bit is high, pick the winner round-robin. Search starts at (rr_ptr+1) mod NUM_REQ and takes the first set bit. On the clock edge:
  - capture the winner's write, addr and wdata into m_write, m_addr and m_wdata;
  - set grant_id and rr_ptr to the winner;
  - go to XFER.
  If no req bit is high, stay in IDLE.
- XFER: m_transfer=1 for exactly this cycle, then go to SETUP.
- SETUP: m_transfer=0. m_ready is ignored here, because the manager is in its SETUP phase. Go to ACCESS.
- ACCESS: m_transfer=0. If m_ready=1, capture m_rdata into rdata, set ack[grant_id], and go to DONE. Otherwise stay in ACCESS; there is no timeout.
- DONE: ack is high for this cycle only. On write transfers rdata holds the captured m_rdata and has no meaning. Go to IDLE.
- m_addr, m_write and m_wdata stay stable from XFER through DONE and keep their values in IDLE until the next grant.
- Because m_transfer is held low in ACCESS, the manager always returns to its IDLE; this block never chains transfers.
- Requester protocol:
  - req_write, req_addr and req_wdata stay stable while req is high.
  - Requesters drop req in the cycle after ack, or keep it high to make a new request.
  - If req is dropped before ack, the transfer still completes and ack still pulses.
- Fairness: with all requesters holding req continuously, grants rotate 0,1,…,NUM_REQ-1,0,… and no requester waits more than NUM_REQ transfers.

## Timing
- Reset values (asynchronous on PRESET): state=IDLE, rr_ptr=NUM_REQ-1 so requester 0 wins first, and grant_id=0. All of these are 0: ack, rdata, busy, m_transfer, m_write, m_addr, m_wdata.
- Cycle trace, with req seen in IDLE at cycle t:
  - t+1: XFER, m_transfer=1.
  - t+2: SETUP.
  - t+3: ACCESS.
  - With m_ready=1 at t+3: DONE and ack at t+4, IDLE at t+5.
- Minimum latency is 4 cycles from req to ack. Each wait state in ACCESS adds 1 cycle. The back-to-back issue period is 5 cycles.
- busy is high from t+1 through the DONE cycle inclusive.
- A new req arriving during XFER, SETUP, ACCESS or DONE is held and only arbitrated in IDLE.
- Simultaneous req bits in IDLE are resolved in the same cycle; no cycle is lost to arbitration.
- PRESET asserted mid-transfer aborts with no ack. All outputs go to reset values immediately, including m_transfer=0, and the requester must re-request after reset.

## Test plan
- Single write, zero wait: req[0]=1, write, addr 0x1000_1004, wdata 0xDEAD_BEEF.
  - m_transfer is high 1 cycle later with those values.
  - ack[0] comes 4 cycles after req; busy is high for 4 cycles.
- Read with 3 wait states: req[1] read of 0x1000_0010; m_ready rises on the 4th ACCESS cycle with m_rdata=0x1234_5678.
  - ack[1] comes 7 cycles after req, with rdata=0x1234_5678.
- Simultaneous requests after reset: req=2'b11 held high.
  - Grants go 0,1,0,1.
  - Each ack is 5 cycles apart, and m_addr alternates between the two requesters' addresses.
- Spurious ready: m_ready=1 during SETUP and 0 in the first ACCESS cycle, then 1 in the second.
  - There is no ack until the cycle after the second ACCESS cycle.
- Reset mid-ACCESS: PRESET pulses during ACCESS of a req[0] read.
  - All outputs are 0 within the reset cycle and no ack pulses.
  - A re-asserted req[0] completes normally with 4-cycle latency.
- Early request drop: req[1] drops during SETUP.
  - ack[1] still pulses, and the following arbitration in IDLE ignores requester 1.
